// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - asynchronous 16-bit SRAM controller with free-running clock divider
//
// Purpose:
//   Turns level read/write requests into timed bus cycles on an external
//   asynchronous 16-bit x 256K SRAM. Each request produces exactly one access,
//   no matter how long the request is held. The controller also latches the
//   read word and shows when it is idle through ready. A free-running divider
//   produces clk_out, which paces the user request logic.
//
// Ports:
//   clk           in     system clock; all state changes on its rising edge
//   reset         in     asynchronous, active-low reset
//   address       in     18-bit word address, latched when a request is accepted
//   data_write    in     16-bit write data, latched when a write is accepted
//   write         in     level write request (has priority over read)
//   read          in     level read request
//   data_read     out    last word read from the SRAM (registered)
//   ready         out    high while idle and accepting a request
//   clk_out       out    divided clock: toggles every DIV_N clk cycles
//   data_pins     inout  SRAM data bus; driven only in the write states
//   address_pins  out    registered SRAM address
//   OE, WE, CS    out    registered active-low SRAM strobes

module sram_ctrl #(
  parameter int unsigned DIV_WIDTH = 32,
  parameter int unsigned DIV_N     = 12000000,
  parameter int unsigned WE_CYCLES = 2,
  parameter int unsigned RD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [17:0] address,
  input  logic [15:0] data_write,
  input  logic        write,
  input  logic        read,
  output logic [15:0] data_read,
  output logic        ready,
  output logic        clk_out,
  inout  wire  [15:0] data_pins,
  output logic [17:0] address_pins,
  output logic        OE,
  output logic        WE,
  output logic        CS
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_SETUP = 3'd1,
    S_WR_PULSE = 3'd2,
    S_WR_HOLD  = 3'd3,
    S_RD_WAIT  = 3'd4,
    S_RD_LATCH = 3'd5,
    S_RELEASE  = 3'd6
  } state_t;

  // The strobe-phase counters count down to zero, so they are loaded with
  // the phase length minus one.
  localparam logic [15:0]          WE_LAST  = 16'(WE_CYCLES - 1);
  localparam logic [15:0]          RD_LAST  = 16'(RD_CYCLES - 1);
  localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(DIV_N - 1);

  state_t              r_state;
  logic [15:0]         r_cnt;
  logic [17:0]         r_addr;
  logic [15:0]         r_wdata;
  logic [15:0]         r_rdata;
  logic                r_drive;
  logic                r_ready;
  logic                r_cs;
  logic                r_oe;
  logic                r_we;
  logic [DIV_WIDTH-1:0] r_div_cnt;
  logic                r_clk_out;

  // The bus enable is a register, so the write data is on the pins for the
  // whole time CS is low in a write cycle, including the setup and hold cycles.
  assign data_pins    = r_drive ? r_wdata : 16'hzzzz;
  assign address_pins = r_addr;
  assign data_read    = r_rdata;
  assign ready        = r_ready;
  assign CS           = r_cs;
  assign OE           = r_oe;
  assign WE           = r_we;
  assign clk_out      = r_clk_out;

  // Access state machine. Each strobe register gets the value for the state
  // being entered, so every SRAM control pin comes straight from a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_drive <= 1'b0;
      r_ready <= 1'b0;
      r_cs    <= 1'b1;
      r_oe    <= 1'b1;
      r_we    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (write) begin
            r_state <= S_WR_SETUP;
            r_addr  <= address;
            r_wdata <= data_write;
            r_drive <= 1'b1;
            r_cs    <= 1'b0;
            r_ready <= 1'b0;
          end else if (read) begin
            r_state <= S_RD_WAIT;
            r_addr  <= address;
            r_cnt   <= RD_LAST;
            r_cs    <= 1'b0;
            r_oe    <= 1'b0;
            r_ready <= 1'b0;
          end else begin
            r_ready <= 1'b1;
          end
        end

        S_WR_SETUP: begin
          r_state <= S_WR_PULSE;
          r_cnt   <= WE_LAST;
          r_we    <= 1'b0;
        end

        S_WR_PULSE: begin
          if (r_cnt == 16'd0) begin
            // The SRAM stores the word on this rising edge of WE. CS and the
            // bus stay asserted for one more cycle of hold time.
            r_state <= S_WR_HOLD;
            r_we    <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end

        S_WR_HOLD: begin
          r_state <= S_RELEASE;
          r_cs    <= 1'b1;
          r_drive <= 1'b0;
        end

        S_RD_WAIT: begin
          if (r_cnt == 16'd0) begin
            r_state <= S_RD_LATCH;
            r_rdata <= data_pins;
            r_cs    <= 1'b1;
            r_oe    <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end

        S_RD_LATCH: begin
          r_state <= S_RELEASE;
        end

        S_RELEASE: begin
          // Wait for the requester to drop its level request, so one long
          // request cannot start a second access.
          if (!read && !write) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_drive <= 1'b0;
          r_ready <= 1'b0;
          r_cs    <= 1'b1;
          r_oe    <= 1'b1;
          r_we    <= 1'b1;
        end
      endcase
    end
  end

  // Free-running divider. It is independent of the access state machine.
  // clk_out toggles on every DIV_N-th edge, which gives a 50% duty cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div_cnt <= '0;
      r_clk_out <= 1'b0;
    end else if (r_div_cnt == DIV_LAST) begin
      r_div_cnt <= '0;
      r_clk_out <= ~r_clk_out;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - randomized self-checking bench for sram_ctrl with a pin-level SRAM model

module tb_sram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [17:0] address;
  logic [15:0] data_write;
  logic        write;
  logic        read;
  wire  [15:0] data_read;
  wire         ready;
  wire         clk_out;
  wire  [15:0] data_pins;
  wire  [17:0] address_pins;
  wire         OE;
  wire         WE;
  wire         CS;

  wire  [15:0] d1_data_read;
  wire         d1_ready;
  wire         d1_clk_out;
  wire  [15:0] d1_data_pins;
  wire  [17:0] d1_address_pins;
  wire         d1_OE;
  wire         d1_WE;
  wire         d1_CS;

  sram_ctrl #(.DIV_WIDTH(32), .DIV_N(3), .WE_CYCLES(2), .RD_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset), .address(address), .data_write(data_write),
    .write(write), .read(read), .data_read(data_read), .ready(ready),
    .clk_out(clk_out), .data_pins(data_pins), .address_pins(address_pins),
    .OE(OE), .WE(WE), .CS(CS)
  );

  sram_ctrl #(.DIV_WIDTH(32), .DIV_N(1), .WE_CYCLES(2), .RD_CYCLES(2)) u_dut_div1 (
    .clk(clk), .reset(reset), .address(18'd0), .data_write(16'd0),
    .write(1'b0), .read(1'b0), .data_read(d1_data_read), .ready(d1_ready),
    .clk_out(d1_clk_out), .data_pins(d1_data_pins), .address_pins(d1_address_pins),
    .OE(d1_OE), .WE(d1_WE), .CS(d1_CS)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Contents of a location that has never been written.
  function automatic logic [15:0] blank_word(input logic [17:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  // Pin-level asynchronous SRAM model: stores on the rising edge of WE while
  // CS is low, and drives the bus while CS and OE are low and WE is high.
  logic [15:0] sram [logic [17:0]];
  logic [15:0] sram_q;
  always @(posedge WE) if (reset && !CS) sram[address_pins] = data_pins;
  always @(clk or address_pins)
    sram_q = sram.exists(address_pins) ? sram[address_pins] : blank_word(address_pins);
  assign data_pins = (!CS && !OE && WE) ? sram_q : 16'hzzzz;

  // Transaction-level reference model.
  logic [15:0] ref_mem [logic [17:0]];
  logic [15:0] last_read = 16'h0000;

  // Divider reference: count the clk edges since reset was released.
  // clk_out is the parity of the number of completed DIV_N-edge blocks.
  int unsigned k_edges = 0;
  always @(posedge clk or negedge reset) begin
    if (!reset) k_edges <= 0;
    else        k_edges <= k_edges + 1;
  end
  always @(negedge clk) begin
    if (reset) begin
      check("clk_out_div3", {31'd0, clk_out}, (k_edges / 3) % 2);
      check("clk_out_div1", {31'd0, d1_clk_out}, k_edges % 2);
    end
  end

  task automatic do_write(input logic [17:0] a, input logic [15:0] d, input int hold, input bit both);
    int cs_n = 0, we_n = 0, oe_n = 0, pulses = 0, first_cs = -1, first_we = -1;
    int bus_bad = 0, addr_bad = 0;
    logic we_prev = 1'b1;
    check("wr_ready_before", {31'd0, ready}, 1);
    address = a; data_write = d; write = 1'b1; read = both;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (i == 0) check("wr_ready_fall", {31'd0, ready}, 0);
      if (!CS) begin
        cs_n++;
        if (first_cs < 0) first_cs = i;
        if (data_pins !== d) bus_bad++;
        if (address_pins !== a) addr_bad++;
      end
      if (!OE) oe_n++;
      if (!WE) begin
        we_n++;
        if (first_we < 0) first_we = i;
        if (we_prev) pulses++;
      end
      we_prev = WE;
      // Changing the inputs after acceptance must not disturb the access.
      if (i == 1) begin address = 18'($urandom); data_write = 16'($urandom); end
    end
    write = 1'b0; read = 1'b0;
    @(negedge clk);
    check("wr_ready_return", {31'd0, ready}, 1);
    check("wr_cs_first", first_cs, 0);
    check("wr_cs_cycles", cs_n, 4);
    check("wr_we_cycles", we_n, 2);
    check("wr_we_pulses", pulses, 1);
    check("wr_we_offset", first_we - first_cs, 1);
    check("wr_oe_low", oe_n, 0);
    check("wr_bus_bad", bus_bad, 0);
    check("wr_addr_bad", addr_bad, 0);
    check("wr_data_read_kept", {16'd0, data_read}, {16'd0, last_read});
    ref_mem[a] = d;
  endtask

  task automatic do_read(input logic [17:0] a, input int hold);
    int cs_n = 0, oe_n = 0, we_n = 0, falls = 0, bus_bad = 0, oe_no_cs = 0;
    logic cs_prev = 1'b1;
    logic [15:0] exp;
    exp = ref_mem.exists(a) ? ref_mem[a] : blank_word(a);
    check("rd_ready_before", {31'd0, ready}, 1);
    address = a; read = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (i == 0) check("rd_ready_fall", {31'd0, ready}, 0);
      if (!CS) begin
        cs_n++;
        if (cs_prev) falls++;
      end
      cs_prev = CS;
      if (!OE) begin
        oe_n++;
        if (CS) oe_no_cs++;
        if (data_pins !== exp) bus_bad++;
      end
      if (!WE) we_n++;
      if (i == 0) address = 18'($urandom);
    end
    read = 1'b0;
    @(negedge clk);
    check("rd_ready_return", {31'd0, ready}, 1);
    check("rd_data", {16'd0, data_read}, {16'd0, exp});
    check("rd_cs_cycles", cs_n, 2);
    check("rd_oe_cycles", oe_n, 2);
    check("rd_oe_without_cs", oe_no_cs, 0);
    check("rd_accesses", falls, 1);
    check("rd_we_low", we_n, 0);
    check("rd_bus_bad", bus_bad, 0);
    check("rd_addr_hold", {14'd0, address_pins}, {14'd0, a});
    last_read = exp;
  endtask

  logic [17:0] pool [8];

  initial begin
    reset = 1'b0; address = '0; data_write = '0; write = 1'b0; read = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs", {31'd0, CS}, 1);
    check("rst_oe", {31'd0, OE}, 1);
    check("rst_we", {31'd0, WE}, 1);
    check("rst_ready", {31'd0, ready}, 0);
    check("rst_data_read", {16'd0, data_read}, 0);
    check("rst_address_pins", {14'd0, address_pins}, 0);
    check("rst_clk_out", {31'd0, clk_out}, 0);
    #2 reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {31'd0, ready}, 1);

    // Directed write and read-back of a fixed word.
    do_write(18'h00005, 16'hAAAA, 20, 1'b0);
    do_read(18'h00005, 12);
    // Simultaneous read and write requests must produce a write.
    do_write(18'h00123, 16'h1234, 9, 1'b1);
    do_read(18'h00123, 7);
    // Reading an unwritten location returns the model's blank pattern.
    do_read(18'h3FFFF, 6);

    for (int i = 0; i < 8; i++) pool[i] = 18'($urandom);
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 9) < 4)
        do_read(pool[$urandom_range(0, 7)], $urandom_range(5, 10));
      else
        do_write(pool[$urandom_range(0, 7)], 16'($urandom), $urandom_range(6, 12),
                 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset in the middle of a read aborts the access at once.
    address = pool[0]; read = 1'b1;
    @(negedge clk);
    check("mid_rd_cs_low", {31'd0, CS}, 0);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_cs", {31'd0, CS}, 1);
    check("mid_rst_oe", {31'd0, OE}, 1);
    check("mid_rst_we", {31'd0, WE}, 1);
    check("mid_rst_ready", {31'd0, ready}, 0);
    check("mid_rst_data_read", {16'd0, data_read}, 0);
    check("mid_rst_address", {14'd0, address_pins}, 0);
    check("mid_rst_clk_out", {31'd0, clk_out}, 0);
    read = 1'b0;
    last_read = 16'h0000;
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check("ready_after_mid_reset", {31'd0, ready}, 1);
    do_write(18'h00777, 16'hC3C3, 7, 1'b0);
    do_read(18'h00777, 6);
    do_read(18'h00005, 6);

    repeat (13) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Single-clock controller for an external asynchronous 16-bit x 256K SRAM (18-bit address, active-low CS/OE/WE, shared bidirectional data bus).
- Converts level read/write requests from user logic into timed SRAM bus cycles.
- Captures read data and reports idle through ready.
- Also contains a free-running clock divider, clk_out, that paces the user request logic.

Parameters:
- DIV_WIDTH, 32, width of the divider counter.
- DIV_N, 12000000, clk_out toggles every DIV_N clk cycles; legal range 1 to 2^DIV_WIDTH-1.
- WE_CYCLES, 2, number of clk cycles WE is held low in a write (>=1).
- RD_CYCLES, 2, number of clk cycles OE/CS are held low before read data is latched (>=1).

Ports:
- clk  in  1  system clock; all state on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- address  in  18  word address for the requested operation.
- data_write  in  16  write data.
- write  in  1  level write request.
- read  in  1  level read request.
- data_read  out  16  last word read; registered.
- ready  out  1  high when the controller is idle and accepting a request.
- clk_out  out  1  divided clock.
- data_pins  inout  16  SRAM data bus; driven only during write states, otherwise high-Z.
- address_pins  out  18  SRAM address; registered.
- OE  out  1  SRAM output enable, active-low.
- WE  out  1  SRAM write enable, active-low.
- CS  out  1  SRAM chip select, active-low.

Behaviour:
Reset (reset=0, asynchronous):
- State goes to IDLE.
- CS=OE=WE=1, data_pins high-Z, address_pins=0, data_read=0, ready=0.
- Divider counter=0, clk_out=0.
- Reset asserted mid-operation aborts the operation immediately with the same values.
- The first rising clk edge after reset release sets ready=1.

States: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_WAIT, RD_LATCH, RELEASE.

IDLE:
- ready=1; CS=OE=WE=1; bus high-Z.
- On an edge with write=1, latch address into address_pins and data_write into an internal register, then go to WR_SETUP.
- Otherwise, on an edge with read=1, latch address and go to RD_WAIT.
- Write has priority when both requests are high.
- ready drops on the same edge that accepts a request.
- Inputs that change after acceptance do not affect the operation in progress.

Write path:
- WR_SETUP (1 cycle): CS=0, WE=1, OE=1, bus driven with the latched data.
- WR_PULSE (WE_CYCLES cycles): CS=0, WE=0, OE=1, bus driven.
- WR_HOLD (1 cycle): CS=0, WE=1, bus still driven.
- Then RELEASE.
- OE is never 0 while the bus is driven.

Read path:
- RD_WAIT (RD_CYCLES cycles): CS=0, OE=0, WE=1, bus high-Z.
- On the edge leaving the last RD_WAIT cycle, data_read <= data_pins.
- RD_LATCH (1 cycle): CS=OE=1.
- Then RELEASE.

RELEASE:
- CS=OE=WE=1, ready=0.
- Stays until read=0 and write=0, then IDLE.
- A request held high for many cycles therefore produces exactly one SRAM access.

Register and output rules:
- data_read holds its value until the next completed read; writes do not alter it.
- address_pins holds the last latched address while idle.
- All SRAM control outputs come from registers (glitch-free).

Clock divider:
- counter increments every clk cycle.
- When counter==DIV_N-1: counter<=0 and clk_out toggles.
- clk_out period = 2*DIV_N clk cycles, 50% duty cycle.
- With DIV_N=1, clk_out = clk/2.
- The divider is independent of the SRAM state machine.

Test Plan:
1. Reset then idle: hold reset=0 for 3 cycles, then release. Required: CS=OE=WE=1, data_pins=Z, data_read=0, ready=0 during reset; ready=1 one edge after release.
2. Single write (WE_CYCLES=2): address=0x00005, data_write=0xAAAA, write=1 held for 20 cycles. Required:
   - ready falls on the accepting edge.
   - CS low for exactly 4 cycles; WE low for exactly 2 cycles, centred inside CS.
   - data_pins=0xAAAA while CS is low; OE stays 1.
   - Exactly one WE pulse occurs; ready returns 1 one cycle after write drops.
3. Read back: an SRAM model returns stored 0xAAAA at address 0x00005; read=1 held. Required:
   - OE=CS=0 for 2 cycles; bus high-Z from the controller.
   - data_read=0xAAAA after RD_LATCH.
   - No second access until read drops.
4. Simultaneous request and mid-operation changes: read=1 and write=1 on the same edge → a write cycle occurs. Change address and data_write during WR_PULSE → address_pins and the bus keep the originally latched values.
5. Reset mid-read: assert reset during RD_WAIT. Required: CS=OE=1 immediately (asynchronous), data_read unchanged-to-0 per reset, state IDLE after release.
6. Divider with DIV_N=3: clk_out toggles every 3 clk cycles (period 6, starting low after reset). Repeat with DIV_N=1 → clk_out period 2.
